// File: rtl/CPU_pkg.sv
// Shared M-extension types: divider op encoding, divider FSM states and op helpers.
// Encoding keeps signedness in bit 0 and DIV/REM selection in bit 1.
package CPU_pkg;

    typedef enum logic [1:0] {
        UDIV = 2'd0,
        SDIV = 2'd1,
        UREM = 2'd2,
        SREM = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic is_signed_op(input div_op_t op);
        return op[0];
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return op[1];
    endfunction

    // DIV <-> REM with the same signedness
    function automatic div_op_t partner_op(input div_op_t op);
        return div_op_t'({~op[1], op[0]});
    endfunction

endpackage

// File: rtl/int_div_unit_if.sv
// Issue-side bus of the integer divider: operand handshake, result handshake and flush.
interface int_div_unit_if
    import CPU_pkg::*;
#(
    parameter int N = 32
);
    logic         flush;
    logic         valid_in;
    logic         ready_out;
    div_op_t      op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         valid_out;
    logic         ready_in;
    logic [N-1:0] y;

    modport master (
        output flush, valid_in, op, a, b, ready_in,
        input  ready_out, valid_out, y
    );

    modport slave (
        input  flush, valid_in, op, a, b, ready_in,
        output ready_out, valid_out, y
    );
endinterface

// File: rtl/int_div_step.sv
// Combinational M-step restoring division stage; dividend slice is consumed MSB first.
// Caller guarantees rem < dsr, so an N+1-bit difference sign decides each quotient bit.
module int_div_step #(
    parameter int N = 32,
    parameter int M = 8
) (
    input  logic [N-1:0] rem,
    input  logic [M-1:0] dvd,
    input  logic [N-1:0] dsr,
    output logic [M-1:0] q,
    output logic [N-1:0] rem_next
);
    logic [N-1:0] r;
    logic [N:0]   sh;
    logic [N:0]   diff;

    always_comb begin
        r    = rem;
        q    = '0;
        sh   = '0;
        diff = '0;
        for (int i = M - 1; i >= 0; i--) begin
            sh   = {r, dvd[i]};
            diff = sh - {1'b0, dsr};
            q[i] = ~diff[N];
            r    = diff[N] ? sh[N-1:0] : diff[N-1:0];
        end
        rem_next = r;
    end
endmodule

// File: rtl/int_div_unit.sv
// Iterative radix-2^M restoring divider with RISC-V special cases, flush and DIV/REM reuse.
// Build option INT_DIV_EARLY_TERM_EN skips leading all-zero dividend digits.
//
// state | meaning
// IDLE  | waiting for an op; a finished result may still be held on y
// CALC  | retiring M quotient bits per cycle
// DONE  | result formed, presented on y/valid_out at the next edge
module int_div_unit
    import CPU_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 8
) (
    input logic           clk,
    input logic           reset,
    int_div_unit_if.slave bus
);
    localparam int ITERS = N / M;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N - 1){1'b0}}};

    if ((M < 1) || (M > N) || ((N % M) != 0)) begin : g_param_check
        $error("int_div_unit: N must be a positive multiple of M");
    end

    div_state_t   state;
    div_op_t      lat_op;
    logic [N-1:0] lat_a, lat_b;
    logic [N-1:0] dvd_q, dsr_q, rem_q;
    logic [N-1:0] res_quo, res_rem, y_q;
    logic [CW-1:0] cnt;
    logic         neg_quo, neg_rem, fast_q, tag_valid, valid_q;

    logic         op_signed, op_rem, ready, accept;
    logic         is_zero, is_ovf, is_reuse;
    logic [N-1:0] abs_a, abs_b, dvd_init, fast_val, quo_fix, rem_fix, rem_nx;
    logic [CW-1:0] iters_init;
    logic [M-1:0] q_bits;

    assign op_signed = is_signed_op(bus.op);
    assign op_rem    = is_rem_op(bus.op);
    assign abs_a     = (op_signed && bus.a[N-1]) ? -bus.a : bus.a;
    assign abs_b     = (op_signed && bus.b[N-1]) ? -bus.b : bus.b;
    assign is_zero   = (bus.b == '0);
    assign is_ovf    = op_signed && (bus.a == MIN_NEG) && (bus.b == '1);
    assign is_reuse  = tag_valid && (bus.op == partner_op(lat_op))
                       && (bus.a == lat_a) && (bus.b == lat_b);

    assign ready     = (state == IDLE) && (!valid_q || bus.ready_in) && !bus.flush;
    assign accept    = bus.valid_in && ready;

    assign bus.ready_out = ready;
    assign bus.valid_out = valid_q;
    assign bus.y         = y_q;

    assign quo_fix = neg_quo ? -dvd_q : dvd_q;
    assign rem_fix = neg_rem ? -rem_q : rem_q;

    always_comb begin
        fast_val = op_rem ? res_rem : res_quo;
        if (is_zero)
            fast_val = op_rem ? bus.a : '1;
        else if (is_ovf)
            fast_val = op_rem ? '0 : bus.a;
    end

`ifdef INT_DIV_EARLY_TERM_EN
    int k;

    function automatic int lzc(input logic [N-1:0] v);
        int n = N;
        for (int i = 0; i < N; i++)
            if (v[i]) n = N - 1 - i;
        return n;
    endfunction

    always_comb begin
        k          = (lzc(abs_a) / M) * M;
        dvd_init   = abs_a << k;
        iters_init = (k >= N) ? CW'(1) : CW'((N - k) / M);
    end
`else
    always_comb begin
        dvd_init   = abs_a;
        iters_init = CW'(ITERS);
    end
`endif

    int_div_step #(.N(N), .M(M)) u_step (
        .rem      (rem_q),
        .dvd      (dvd_q[N-1 -: M]),
        .dsr      (dsr_q),
        .q        (q_bits),
        .rem_next (rem_nx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_op    <= UDIV;
            lat_a     <= '0;
            lat_b     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            res_quo   <= '0;
            res_rem   <= '0;
            y_q       <= '0;
            cnt       <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            fast_q    <= 1'b0;
            tag_valid <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.flush) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            tag_valid <= 1'b0;
        end else begin
            if (valid_q && bus.ready_in)
                valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_zero || is_ovf || is_reuse) begin
                            state  <= DONE;
                            fast_q <= 1'b1;
                            dvd_q  <= fast_val;
                            if (!is_reuse)
                                tag_valid <= 1'b0;
                        end else begin
                            // lat_a/lat_b are the reuse tag, so it is invalid until this op finishes
                            state     <= CALC;
                            fast_q    <= 1'b0;
                            tag_valid <= 1'b0;
                            lat_op    <= bus.op;
                            lat_a     <= bus.a;
                            lat_b     <= bus.b;
                            dvd_q     <= dvd_init;
                            dsr_q     <= abs_b;
                            rem_q     <= '0;
                            cnt       <= iters_init;
                            neg_quo   <= op_signed && (bus.a[N-1] ^ bus.b[N-1]);
                            neg_rem   <= op_signed && bus.a[N-1];
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    dvd_q <= (dvd_q << M) | N'(q_bits);
                    if (cnt == CW'(1))
                        state <= DONE;
                    else
                        cnt <= cnt - CW'(1);
                end
                DONE: begin
                    state   <= IDLE;
                    valid_q <= 1'b1;
                    y_q     <= fast_q ? dvd_q : (is_rem_op(lat_op) ? rem_fix : quo_fix);
                    if (!fast_q) begin
                        res_quo   <= quo_fix;
                        res_rem   <= rem_fix;
                        tag_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_div_unit.sv
// Directed self-checking bench for int_div_unit (N=32, M=8, default build).
module tb_int_div_unit;
    import CPU_pkg::*;

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   rises;

    int_div_unit_if #(.N(32)) bus ();

    int_div_unit #(.N(32), .M(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        bus.valid_in = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        #1;
        chk({tag, " ready_out"}, 32'(bus.ready_out), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    // Latency counts edges after the accept edge until valid_out is seen.
    task automatic wait_result(input string tag, input logic [31:0] exp_y, input int exp_lat);
        int lat = 0;
        while (bus.valid_out !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " y"}, bus.y, exp_y);
    endtask

    task automatic run(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_y, input int exp_lat, input string tag);
        start(op, a, b, tag);
        wait_result(tag, exp_y, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        bus.op       = UDIV;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(negedge clk);
        chk("reset valid_out", 32'(bus.valid_out), 32'd0);
        chk("reset y", bus.y, 32'd0);
        chk("reset ready_out", 32'(bus.ready_out), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        run(UDIV, 32'd100, 32'd7, 32'd14, 5, "udiv 100/7");
        run(UREM, 32'd100, 32'd7, 32'd2, 1, "urem 100/7 reuse");
        run(SDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5, "sdiv -7/2");
        run(SREM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, "srem -7/2 reuse");
        run(SREM, 32'd7, 32'hFFFF_FFFE, 32'd1, 5, "srem 7/-2");
        run(UDIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "udiv 5/0");
        run(UREM, 32'd5, 32'd0, 32'd5, 1, "urem 5/0");
        run(SDIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, "sdiv -5/0");
        run(SREM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "srem -5/0");
        run(SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "sdiv ovf");
        run(SREM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "srem ovf");
        run(UDIV, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 5, "udiv max/3");
        run(SDIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 5, "sdiv min/2");
        run(SREM, 32'h8000_0000, 32'd2, 32'd0, 1, "srem min/2 reuse");

        // a special-case op in between must kill the reuse tag
        run(UDIV, 32'd100, 32'd7, 32'd14, 5, "udiv 100/7 again");
        run(UDIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "udiv 5/0 tag kill");
        run(UREM, 32'd100, 32'd7, 32'd2, 5, "urem 100/7 no reuse");

        // backpressure, then back-to-back accept on the consuming edge
        bus.ready_in = 1'b0;
        start(UDIV, 32'd1000, 32'd10, "udiv 1000/10 bp");
        wait_result("udiv 1000/10 bp", 32'd100, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold y", bus.y, 32'd100);
            chk("hold valid_out", 32'(bus.valid_out), 32'd1);
            chk("hold ready_out", 32'(bus.ready_out), 32'd0);
        end
        bus.ready_in = 1'b1;
        start(UREM, 32'd1000, 32'd10, "urem 1000/10 back-to-back");
        wait_result("urem 1000/10 back-to-back", 32'd0, 1);
        @(negedge clk);

        // flush in the second CALC cycle
        start(UDIV, 32'd200, 32'd9, "udiv 200/9 flushed");
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush ready_out low", 32'(bus.ready_out), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("post-flush valid_out", 32'(bus.valid_out), 32'd0);
        chk("post-flush ready_out", 32'(bus.ready_out), 32'd1);
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.valid_out === 1'b1) rises++;
            @(negedge clk);
        end
        chk("flushed op never valid", 32'(rises), 32'd0);
        run(UREM, 32'd200, 32'd9, 32'd2, 5, "urem 200/9 after flush");

        // reset in the middle of CALC
        start(UDIV, 32'd300, 32'd7, "udiv 300/7 pre-reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid-calc reset valid_out", 32'(bus.valid_out), 32'd0);
        chk("mid-calc reset y", bus.y, 32'd0);
        chk("mid-calc reset ready_out", 32'(bus.ready_out), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(UDIV, 32'd300, 32'd7, 32'd42, 5, "udiv 300/7");
        run(UREM, 32'd300, 32'd7, 32'd6, 1, "urem 300/7 reuse");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
